// File: rtl/cache_line_mem_responder.sv
// Memory-side responder for the 128-bit cache-line protocol: line storage that answers
// one request at a time with a single-cycle ready pulse after a fixed latency.
module cache_line_mem_responder #(
    parameter int LINE_AW = 10,
    parameter int LATENCY = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         busy,
    output logic         proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int            DEPTH    = 1 << LINE_AW;
    localparam logic [7:0]    CNT_INIT = 8'(LATENCY - 1);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 is_wr_q, is_wr_d;
    logic                 perr_q, perr_d;
    logic [127:0]         rdata_q, rdata_d;
    logic [LINE_AW-1:0]   idx_q, idx_d;
    logic [127:0]         wdata_q, wdata_d;

    logic [127:0]         mem_q [DEPTH];
    logic                 mem_we;
    logic                 enter_resp;
    logic [LINE_AW-1:0]   rd_idx;

    // Upper line-address bits alias onto the same storage by design.
    logic unused_addr;
    assign unused_addr = ^mem_addr[27:LINE_AW];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        perr_d     = perr_q;
        rdata_d    = rdata_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;
        enter_resp = 1'b0;
        rd_idx     = idx_q;

        case (state_q)
            IDLE: begin
                // With LATENCY=1 the response is entered on the accept edge, so the
                // read index must come straight from the bus rather than the latch.
                rd_idx = mem_addr[LINE_AW-1:0];
                if (mem_read || mem_write) begin
                    is_wr_d = mem_write;
                    idx_d   = mem_addr[LINE_AW-1:0];
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_INIT;
                    if (mem_read && mem_write) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d      = 8'd0;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                mem_we  = is_wr_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp && !is_wr_d) begin
            rdata_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            is_wr_q <= 1'b0;
            perr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            perr_q  <= perr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // A reset landing on the RESP cycle drops the pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign proto_err = perr_q;

endmodule
